// File: rtl/bus_cdc_arbiter.sv
// Round-robin arbiter sharing one CDC-bound bus among NUM_REQ masters (optional WAIT timeout: BUS_ARB_TIMEOUT_EN).
// Latency: request sampled at edge k -> strobe in cycle k+1, done_o in k+3 when bus_halt_i is low.
// Backpressure: bus_halt_i stretches WAIT; non-owner requests are held off until the arbiter is idle again.
module bus_cdc_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      err_o,
    output logic [ADDR_W-1:0]         bus_addr_o,
    output logic [DATA_W-1:0]         bus_wdata_o,
    output logic                      bus_we_o,
    output logic                      bus_re_o,
    input  logic                      bus_halt_i,
    input  logic [DATA_W-1:0]         bus_rdata_i
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic            cmd_we;
    logic [PW-1:0]   win;
    logic            win_vld;
    logic            to_hit;

    // First requester after the last winner, wrapping modulo NUM_REQ.
    always_comb begin
        win     = rr_ptr;
        win_vld = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!win_vld && req_i[PW'((int'(rr_ptr) + i) % NUM_REQ)]) begin
                win     = PW'((int'(rr_ptr) + i) % NUM_REQ);
                win_vld = 1'b1;
            end
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] to_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i || state == ISSUE) begin
            to_cnt <= '0;
        end else if (state == WAIT) begin
            to_cnt <= to_cnt + CW'(1);
        end
    end

    assign to_hit = (to_cnt + CW'(1)) == CW'(TIMEOUT_CYCLES);
`else
    assign to_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            rr_ptr      <= PW'(NUM_REQ - 1);
            cmd_we      <= 1'b0;
            grant_o     <= '0;
            done_o      <= '0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_we_o    <= 1'b0;
            bus_re_o    <= 1'b0;
        end else begin
            bus_we_o <= 1'b0;
            bus_re_o <= 1'b0;
            done_o   <= '0;
            err_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        // Strobes are registered here so they are visible during ISSUE.
                        bus_addr_o  <= addr_i[int'(win)*ADDR_W +: ADDR_W];
                        bus_wdata_o <= wdata_i[int'(win)*DATA_W +: DATA_W];
                        cmd_we      <= we_i[win];
                        bus_we_o    <= we_i[win];
                        bus_re_o    <= !we_i[win];
                        grant_o     <= NUM_REQ'(1) << win;
                        rr_ptr      <= win;
                        state       <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (!bus_halt_i) begin
                        if (!cmd_we) begin
                            rdata_o <= bus_rdata_i;
                        end
                        done_o <= grant_o;
                        state  <= DONE;
                    end else if (to_hit) begin
                        rdata_o <= '0;
                        err_o   <= 1'b1;
                        done_o  <= grant_o;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    grant_o <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_cdc_arbiter.sv
// Randomized bench for bus_cdc_arbiter against a transaction-level round-robin model.
module tb_bus_cdc_arbiter;
    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [3:0]   req_i;
    logic [3:0]   we_i;
    logic [127:0] addr_i;
    logic [127:0] wdata_i;
    logic [3:0]   grant_o;
    logic [3:0]   done_o;
    logic [31:0]  rdata_o;
    logic         err_o;
    logic [31:0]  bus_addr_o;
    logic [31:0]  bus_wdata_o;
    logic         bus_we_o;
    logic         bus_re_o;
    logic         bus_halt_i;
    logic [31:0]  bus_rdata_i;

    bus_cdc_arbiter #(
        .NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .grant_o(grant_o), .done_o(done_o),
        .rdata_o(rdata_o), .err_o(err_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_we_o(bus_we_o), .bus_re_o(bus_re_o),
        .bus_halt_i(bus_halt_i), .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int          n_vec = 0;
    int          n_bad = 0;
    int          last  = 3;
    logic [31:0] exp_rdata = '0;
    logic        c_we    [4];
    logic [31:0] c_addr  [4];
    logic [31:0] c_wdata [4];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input int from, input logic [3:0] pend);
        for (int i = 1; i <= 4; i++) begin
            if (pend[(from + i) % 4]) return (from + i) % 4;
        end
        return 0;
    endfunction

    task automatic drive_cmd(input int n);
        we_i[n]            = c_we[n];
        addr_i[n*32 +: 32] = c_addr[n];
        wdata_i[n*32 +: 32] = c_wdata[n];
    endtask

    task automatic new_cmd(input int n);
        c_we[n]    = 1'($urandom_range(0, 1));
        c_addr[n]  = $urandom;
        c_wdata[n] = $urandom;
        drive_cmd(n);
    endtask

    // Called at a negedge while the arbiter is idle; returns at the bubble cycle after the last done.
    task automatic run_batch(input logic [3:0] mask, input bit rand_cmd, input int hl_fix, input bit chaos);
        logic [3:0]  pend;
        logic [31:0] rd;
        int          w, hl, nre;
        bit          dropped;
        pend = mask;
        nre  = 0;
        for (int n = 0; n < 4; n++) begin
            if (mask[n]) begin
                if (rand_cmd) new_cmd(n); else drive_cmd(n);
                req_i[n] = 1'b1;
            end
        end
        while (pend != 4'b0) begin
            w       = pick(last, pend);
            hl      = (hl_fix >= 0) ? hl_fix : int'($urandom_range(0, 3));
            rd      = $urandom;
            dropped = 1'b0;
            @(negedge clk_i);
            check_eq("issue_grant", grant_o, 64'(4'b1 << w));
            check_eq("issue_strobe", {bus_we_o, bus_re_o}, c_we[w] ? 2'b10 : 2'b01);
            check_eq("issue_addr", bus_addr_o, c_addr[w]);
            check_eq("issue_wdata", bus_wdata_o, c_wdata[w]);
            bus_rdata_i = rd;
            for (int j = 0; j <= hl; j++) begin
                @(negedge clk_i);
                check_eq("wait_done", done_o, 0);
                check_eq("wait_strobe", {bus_we_o, bus_re_o}, 0);
                check_eq("wait_addr", bus_addr_o, c_addr[w]);
                bus_halt_i  = (j < hl);
                bus_rdata_i = (j < hl) ? $urandom : rd;
                if (chaos && j == 0 && $urandom_range(0, 3) == 0) begin
                    req_i[w] = 1'b0;
                    dropped  = 1'b1;
                end
            end
            @(negedge clk_i);
            if (!c_we[w]) exp_rdata = rd;
            check_eq("done_pulse", done_o, 64'(4'b1 << w));
            check_eq("done_rdata", rdata_o, exp_rdata);
            check_eq("done_err", err_o, 0);
            check_eq("done_grant", grant_o, 64'(4'b1 << w));
            last = w;
            if (!dropped && chaos && nre < 2 && $urandom_range(0, 2) == 0) begin
                new_cmd(w);
                nre++;
            end else begin
                req_i[w] = 1'b0;
                pend[w]  = 1'b0;
            end
            @(negedge clk_i);
            check_eq("bubble_grant", grant_o, 0);
            check_eq("bubble_done", done_o, 0);
            check_eq("bubble_strobe", {bus_we_o, bus_re_o}, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset_i     = 1'b1;
        req_i       = '0;
        we_i        = '0;
        addr_i      = '0;
        wdata_i     = '0;
        bus_halt_i  = 1'b0;
        bus_rdata_i = '0;
        repeat (3) @(negedge clk_i);
        check_eq("rst_grant", grant_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_rdata", rdata_o, 0);
        check_eq("rst_err", err_o, 0);
        check_eq("rst_bus", {bus_addr_o, bus_wdata_o}, 0);
        check_eq("rst_strobe", {bus_we_o, bus_re_o}, 0);
        reset_i = 1'b0;

        c_we[1] = 1'b0; c_addr[1] = 32'h0000_0104; c_wdata[1] = 32'h0;
        run_batch(4'b0010, 1'b0, 0, 1'b0);
        c_we[0] = 1'b1; c_addr[0] = 32'h10; c_wdata[0] = 32'h55;
        run_batch(4'b0001, 1'b0, 5, 1'b0);
        run_batch(4'b1111, 1'b1, 0, 1'b0);

        for (int b = 0; b < 30; b++) begin
            run_batch(4'($urandom_range(1, 15)), 1'b1, -1, 1'b1);
        end

        // Reset during WAIT aborts without a done pulse.
        new_cmd(2);
        req_i[2] = 1'b1;
        @(negedge clk_i);
        bus_halt_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        check_eq("rstmid_grant", grant_o, 0);
        check_eq("rstmid_done", done_o, 0);
        reset_i    = 1'b0;
        req_i      = '0;
        bus_halt_i = 1'b0;
        last       = 3;
        exp_rdata  = '0;
        run_batch(4'b1001, 1'b1, 0, 1'b0);
        run_batch(4'b1111, 1'b1, 0, 1'b0);

        // Halt stuck high.
        c_we[0] = 1'b0; c_addr[0] = 32'h200; c_wdata[0] = 32'h0;
        drive_cmd(0);
        req_i[0] = 1'b1;
        @(negedge clk_i);
        check_eq("to_grant", grant_o, 4'b0001);
        bus_halt_i = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
        for (int j = 0; j < 8; j++) begin
            @(negedge clk_i);
            check_eq("to_wait_done", done_o, 0);
        end
        @(negedge clk_i);
        check_eq("to_done", done_o, 4'b0001);
        check_eq("to_err", err_o, 1);
        check_eq("to_rdata", rdata_o, 0);
        req_i      = '0;
        bus_halt_i = 1'b0;
        @(negedge clk_i);
        check_eq("to_bubble", grant_o, 0);
        last      = 0;
        exp_rdata = '0;
`else
        seen = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk_i);
            if (done_o != 4'b0) seen = 1'b1;
        end
        check_eq("no_timeout_done", seen, 0);
        check_eq("stuck_grant", grant_o, 4'b0001);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i    = 1'b0;
        req_i      = '0;
        bus_halt_i = 1'b0;
        last       = 3;
        exp_rdata  = '0;
`endif
        run_batch(4'b0110, 1'b1, -1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
